// File: rtl/usart_fifo2rib_if.sv
// usart_fifo2rib_if: RIB slave bus bundle for the UART peripheral
interface usart_fifo2rib_if;
    logic [31:0] addr;
    logic        wrcs;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        req;
    logic        gnt;
    logic        rsp;
    logic        rdy;
    modport master (output addr, wrcs, mask, wdata, req, rdy, input rdata, gnt, rsp);
    modport slave  (input addr, wrcs, mask, wdata, req, rdy, output rdata, gnt, rsp);
endinterface

// File: rtl/usart_fifo2rib.sv
// usart_fifo2rib: 8N1 UART with TX/RX FIFOs, baud divisor, sticky errors and IRQ on the RIB bus
module usart_fifo2rib #(
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    usart_fifo2rib_if.slave rib,
    input  logic            i_rx,
    output logic            o_tx,
    output logic            o_irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [4:0] A_STAT = 5'h00, A_TXD = 5'h04, A_RXD = 5'h08,
                           A_DIV = 5'h0C, A_IEN = 5'h10, A_RXL = 5'h14;

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;

    logic [4:0]  a;
    logic        wr, rd;
    logic [31:0] bmask, rd_val, rdata_q, rdata_d;
    logic        rsp_q, rsp_d, irq_q, irq_d, tx_q, tx_d;
    logic [DIV_W-1:0] div_q, div_d, div_m;
    logic [2:0]  ien_q, ien_d;
    logic        rx_ovf_q, rx_ovf_d, rx_ferr_q, rx_ferr_d, tx_ovf_q, tx_ovf_d;
    logic [2:0]  clr;
    logic [7:0]  status;

    logic [7:0]  tx_mem [TX_DEPTH];
    logic [7:0]  rx_mem [RX_DEPTH];
    logic [TAW:0] txw_q, txw_d, txr_q, txr_d, tx_level;
    logic [RAW:0] rxw_q, rxw_d, rxr_q, rxr_d, rx_level;
    logic        tx_empty, tx_full, rx_empty, rx_full, tx_idle;
    logic        tx_wreq, tx_push, tx_pop, tx_ovf_set;
    logic        rx_push, rx_pop, rx_done, rx_ovf_set, rx_ferr_set;

    tx_st_t      tst_q, tst_d;
    logic [DIV_W-1:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d;
    logic [2:0]  tbit_q, tbit_d;
    logic [7:0]  tsh_q, tsh_d;
    logic        tend;

    rx_st_t      rst_q, rst_d;
    logic [DIV_W-1:0] rcnt_q, rcnt_d, rdiv_q, rdiv_d;
    logic [2:0]  rbit_q, rbit_d;
    logic [7:0]  rsh_q, rsh_d;
    logic [2:0]  sync_q, sync_d;
    logic        line, fall, rend;

    logic        unused_bits;
    assign unused_bits = &{1'b0, rib.addr[31:5], rib.wdata[31:8], rib.rdy};

    assign a        = rib.addr[4:0];
    assign wr       = rib.req & rib.wrcs;
    assign rd       = rib.req & ~rib.wrcs;
    assign rib.gnt  = rib.req;
    assign rib.rdata = rdata_q;
    assign rib.rsp  = rsp_q;
    assign o_irq    = irq_q;
    assign o_tx     = tx_q;

    assign tx_empty = txw_q == txr_q;
    assign tx_full  = (txw_q[TAW] != txr_q[TAW]) && (txw_q[TAW-1:0] == txr_q[TAW-1:0]);
    assign rx_empty = rxw_q == rxr_q;
    assign rx_full  = (rxw_q[RAW] != rxr_q[RAW]) && (rxw_q[RAW-1:0] == rxr_q[RAW-1:0]);
    assign tx_level = txw_q - txr_q;
    assign rx_level = rxw_q - rxr_q;
    assign tx_idle  = tx_empty && tst_q == T_IDLE;
    assign status   = {tx_ovf_q, rx_ferr_q, rx_ovf_q, rx_full, ~rx_empty, tx_full, tx_empty, tx_idle};

    // FIFO pointers, register writes, sticky flags, read mux and IRQ
    always_comb begin
        bmask      = {{8{rib.mask[3]}}, {8{rib.mask[2]}}, {8{rib.mask[1]}}, {8{rib.mask[0]}}};
        div_m      = DIV_W'((32'(div_q) & ~bmask) | (rib.wdata & bmask));
        div_d      = (wr && a == A_DIV) ? ((div_m < DIV_W'(4)) ? DIV_W'(4) : div_m) : div_q;
        ien_d      = (wr && a == A_IEN && rib.mask[0]) ? rib.wdata[2:0] : ien_q;
        tx_wreq    = wr && a == A_TXD && rib.mask[0];
        tx_push    = tx_wreq && (!tx_full || tx_pop);
        tx_ovf_set = tx_wreq && tx_full && !tx_pop;
        rx_pop     = rd && a == A_RXD && !rx_empty;
        rx_push    = rx_done && (!rx_full || rx_pop);
        rx_ovf_set = rx_done && rx_full && !rx_pop;
        txw_d      = txw_q + (TAW+1)'(tx_push);
        txr_d      = txr_q + (TAW+1)'(tx_pop);
        rxw_d      = rxw_q + (RAW+1)'(rx_push);
        rxr_d      = rxr_q + (RAW+1)'(rx_pop);
        clr        = (wr && a == A_STAT && rib.mask[0]) ? rib.wdata[7:5] : 3'b0;
        rx_ovf_d   = rx_ovf_set  | (rx_ovf_q  & ~clr[0]);
        rx_ferr_d  = rx_ferr_set | (rx_ferr_q & ~clr[1]);
        tx_ovf_d   = tx_ovf_set  | (tx_ovf_q  & ~clr[2]);
        rd_val     = (a == A_STAT) ? {24'b0, status} :
                     (a == A_TXD)  ? {16'b0, 16'(tx_level)} :
                     (a == A_RXD)  ? (rx_empty ? 32'b0 : {1'b1, 23'b0, rx_mem[rxr_q[RAW-1:0]]}) :
                     (a == A_DIV)  ? 32'(div_q) :
                     (a == A_IEN)  ? {29'b0, ien_q} :
                     (a == A_RXL)  ? {16'b0, 16'(rx_level)} : 32'b0;
        rdata_d    = rd ? rd_val : 32'b0;
        rsp_d      = rib.req;
        irq_d      = (ien_q[0] & tx_empty) | (ien_q[1] & ~rx_empty) |
                     (ien_q[2] & (rx_ovf_q | rx_ferr_q | tx_ovf_q));
    end

    // TX engine: each state lasts the divisor latched at frame start; frames chain with no gap
    always_comb begin
        tst_d  = tst_q;
        tcnt_d = tcnt_q;
        tdiv_d = tdiv_q;
        tbit_d = tbit_q;
        tsh_d  = tsh_q;
        tx_pop = 1'b0;
        tend   = tcnt_q == tdiv_q - DIV_W'(1);
        if (tst_q == T_IDLE || (tst_q == T_STOP && tend)) begin
            tcnt_d = '0;
            tst_d  = tx_empty ? T_IDLE : T_START;
            tx_pop = !tx_empty;
            tsh_d  = tx_empty ? tsh_q : tx_mem[txr_q[TAW-1:0]];
            tdiv_d = tx_empty ? tdiv_q : div_q;
        end else if (!tend) begin
            tcnt_d = tcnt_q + DIV_W'(1);
        end else if (tst_q == T_START) begin
            tcnt_d = '0;
            tbit_d = 3'd0;
            tst_d  = T_DATA;
        end else begin
            tcnt_d = '0;
            tsh_d  = tsh_q >> 1;
            tbit_d = tbit_q + 3'd1;
            tst_d  = (tbit_q == 3'd7) ? T_STOP : T_DATA;
        end
        tx_d = (tst_d == T_START) ? 1'b0 : (tst_d == T_DATA) ? tsh_d[0] : 1'b1;
    end

    // RX engine: synchronised line, mid-bit sampling, glitch reject and framing-error wait
    always_comb begin
        sync_d      = {sync_q[1:0], i_rx};
        line        = sync_q[1];
        fall        = sync_q[2] & ~sync_q[1];
        rend        = rcnt_q == rdiv_q - DIV_W'(1);
        rst_d       = rst_q;
        rcnt_d      = rcnt_q + DIV_W'(1);
        rdiv_d      = rdiv_q;
        rbit_d      = rbit_q;
        rsh_d       = rsh_q;
        rx_done     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rst_q)
            R_IDLE: begin
                rcnt_d = '0;
                rdiv_d = fall ? div_q : rdiv_q;
                rst_d  = fall ? R_START : R_IDLE;
            end
            R_START: if (rcnt_q == (rdiv_q >> 1)) begin
                rcnt_d = '0;
                rbit_d = 3'd0;
                rst_d  = line ? R_IDLE : R_DATA;
            end
            R_DATA: if (rend) begin
                rcnt_d = '0;
                rsh_d  = {line, rsh_q[7:1]};
                rbit_d = rbit_q + 3'd1;
                rst_d  = (rbit_q == 3'd7) ? R_STOP : R_DATA;
            end
            R_STOP: if (rend) begin
                rcnt_d      = '0;
                rx_done     = line;
                rx_ferr_set = !line;
                rst_d       = line ? R_IDLE : R_WAIT;
            end
            R_WAIT: begin
                rcnt_d = '0;
                rst_d  = line ? R_IDLE : R_WAIT;
            end
            default: rst_d = R_IDLE;
        endcase
    end

    // FIFO storage carries no reset; emptiness is defined by the pointers alone
    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[txw_q[TAW-1:0]] <= rib.wdata[7:0];
        if (rx_push) rx_mem[rxw_q[RAW-1:0]] <= rsh_q;
    end

    // State register for bus, FIFOs and both engines
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_q   <= '0;
            rsp_q     <= 1'b0;
            irq_q     <= 1'b0;
            tx_q      <= 1'b1;
            div_q     <= DIV_W'(DEFAULT_DIV);
            ien_q     <= '0;
            rx_ovf_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
            txw_q     <= '0;
            txr_q     <= '0;
            rxw_q     <= '0;
            rxr_q     <= '0;
            tst_q     <= T_IDLE;
            tcnt_q    <= '0;
            tdiv_q    <= DIV_W'(DEFAULT_DIV);
            tbit_q    <= '0;
            tsh_q     <= '0;
            rst_q     <= R_IDLE;
            rcnt_q    <= '0;
            rdiv_q    <= DIV_W'(DEFAULT_DIV);
            rbit_q    <= '0;
            rsh_q     <= '0;
            sync_q    <= 3'b111;
        end else begin
            rdata_q   <= rdata_d;
            rsp_q     <= rsp_d;
            irq_q     <= irq_d;
            tx_q      <= tx_d;
            div_q     <= div_d;
            ien_q     <= ien_d;
            rx_ovf_q  <= rx_ovf_d;
            rx_ferr_q <= rx_ferr_d;
            tx_ovf_q  <= tx_ovf_d;
            txw_q     <= txw_d;
            txr_q     <= txr_d;
            rxw_q     <= rxw_d;
            rxr_q     <= rxr_d;
            tst_q     <= tst_d;
            tcnt_q    <= tcnt_d;
            tdiv_q    <= tdiv_d;
            tbit_q    <= tbit_d;
            tsh_q     <= tsh_d;
            rst_q     <= rst_d;
            rcnt_q    <= rcnt_d;
            rdiv_q    <= rdiv_d;
            rbit_q    <= rbit_d;
            rsh_q     <= rsh_d;
            sync_q    <= sync_d;
        end
    end
endmodule
